// File: rtl/regdec_pkg.sv
// Shared types and field positions for the register-read/decode stage.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package regdec_pkg;

    typedef enum logic [1:0] {
        SRC_REG   = 2'b00,
        SRC_IMM9  = 2'b01,
        SRC_IMM12 = 2'b10,
        SRC_IMM19 = 2'b11
    } alu_src_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_e;

    // Instruction field positions (LSB of each field)
    localparam int REG_IDX_W  = 5;
    localparam int RS1_LSB    = 5;   // Rn  [9:5]
    localparam int RS2_HI_LSB = 16;  // Rm  [20:16]
    localparam int RS2_LO_LSB = 0;   // Rt  [4:0]
    localparam int IMM9_LSB   = 12;  // [20:12]
    localparam int IMM12_LSB  = 10;  // [21:10]
    localparam int IMM19_LSB  = 5;   // [23:5]

    // Youngest producer wins: EX beats MEM beats the register file.
    function automatic fwd_sel_e fwd_select(
        input logic [REG_IDX_W-1:0] rs,
        input logic [REG_IDX_W-1:0] zero_reg,
        input logic                 ex_hit_en,
        input logic [REG_IDX_W-1:0] ex_rd,
        input logic                 mem_hit_en,
        input logic [REG_IDX_W-1:0] mem_rd
    );
        if (rs == zero_reg)                return FWD_REG;
        if (ex_hit_en && (ex_rd == rs))    return FWD_EX;
        if (mem_hit_en && (mem_rd == rs))  return FWD_MEM;
        return FWD_REG;
    endfunction

endpackage

// File: rtl/regdec_if.sv
// IF/ID-to-ID/EX pipeline signal bundle for the register-read/decode stage.
// Latency: n/a (wiring only).
// Backpressure: stall flows back to the IF/ID side through this bundle.
interface regdec_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 15
);
    logic [31:0]       instr_in;
    logic              valid_in;
    logic [CTRL_W-1:0] ctrl_in;
    logic [1:0]        alu_src;
    logic              reg2loc;
    logic              uses_rs2;
    logic              flush;
    logic              stall;
    logic              zero;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] store_data;
    logic [31:0]       instr_out;
    logic [CTRL_W-1:0] ctrl_out;
    logic              valid_out;

    modport master (
        output instr_in, valid_in, ctrl_in, alu_src, reg2loc, uses_rs2, flush,
        input  stall, zero, alu_a, alu_b, store_data, instr_out, ctrl_out, valid_out
    );

    modport slave (
        input  instr_in, valid_in, ctrl_in, alu_src, reg2loc, uses_rs2, flush,
        output stall, zero, alu_a, alu_b, store_data, instr_out, ctrl_out, valid_out
    );
endinterface

// File: rtl/regfile_bypass.sv
// 32-entry register file, ZERO_REG hardwired to 0, two read ports with write bypass.
// Latency: reads combinational; writes land on the next posedge.
// Backpressure: none; writes are never held off.
module regfile_bypass
    import regdec_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int ZERO_REG = 31
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [REG_IDX_W-1:0] raddr1,
    output logic [DATA_W-1:0]    rdata1,
    input  logic [REG_IDX_W-1:0] raddr2,
    output logic [DATA_W-1:0]    rdata2
);
    localparam logic [REG_IDX_W-1:0] ZR = REG_IDX_W'(ZERO_REG);

    logic [DATA_W-1:0] regs [32];
    logic              wr_ok;

    assign wr_ok = we && (waddr != ZR);

    // Array update; the zero register is never written so it stays 0
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

    // Read port 1 with same-cycle write bypass
    always_comb begin
        rdata1 = regs[raddr1];
        if (raddr1 == ZR)                   rdata1 = '0;
        else if (wr_ok && waddr == raddr1)  rdata1 = wdata;
    end

    // Read port 2 with same-cycle write bypass
    always_comb begin
        rdata2 = regs[raddr2];
        if (raddr2 == ZR)                   rdata2 = '0;
        else if (wr_ok && waddr == raddr2)  rdata2 = wdata;
    end
endmodule

// File: rtl/regdec_stage.sv
// Register read, EX/MEM forwarding, immediate select and load-use detection into ID/EX.
// Latency: 1 cycle from instr_in to the ID/EX outputs.
// Backpressure: stall (load-use) or flush inserts a bubble; stall holds PC and IF/ID upstream.
module regdec_stage
    import regdec_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int CTRL_W   = 15,
    parameter int ZERO_REG = 31
) (
    input  logic                 clk,
    input  logic                 reset,
    regdec_if.slave              bus,
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]    wb_data,
    input  logic                 ex_valid,
    input  logic                 ex_regwrite,
    input  logic                 ex_memread,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic [DATA_W-1:0]    ex_result,
    input  logic                 mem_valid,
    input  logic                 mem_regwrite,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic [DATA_W-1:0]    mem_result
);
    localparam logic [REG_IDX_W-1:0] ZR = REG_IDX_W'(ZERO_REG);

    typedef struct packed {
        logic [DATA_W-1:0] alu_a;
        logic [DATA_W-1:0] alu_b;
        logic [DATA_W-1:0] store_data;
        logic [31:0]       instr;
        logic [CTRL_W-1:0] ctrl;
        logic              valid;
    } idex_t;

    logic [REG_IDX_W-1:0] rs1, rs2;
    logic [DATA_W-1:0]    rf_rs1, rf_rs2, fwd_rs1, fwd_rs2, imm, op_b;
    fwd_sel_e             sel1, sel2;
    alu_src_e             src;
    idex_t                idex_d, idex_q;

    assign rs1 = bus.instr_in[RS1_LSB +: REG_IDX_W];
    assign rs2 = bus.reg2loc ? bus.instr_in[RS2_HI_LSB +: REG_IDX_W]
                             : bus.instr_in[RS2_LO_LSB +: REG_IDX_W];
    assign src = alu_src_e'(bus.alu_src);

    regfile_bypass #(.DATA_W(DATA_W), .ZERO_REG(ZERO_REG)) u_rf (
        .clk    (clk),
        .reset  (reset),
        .we     (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (rs1),
        .rdata1 (rf_rs1),
        .raddr2 (rs2),
        .rdata2 (rf_rs2)
    );

    assign sel1 = fwd_select(rs1, ZR, ex_valid & ex_regwrite, ex_rd, mem_valid & mem_regwrite, mem_rd);
    assign sel2 = fwd_select(rs2, ZR, ex_valid & ex_regwrite, ex_rd, mem_valid & mem_regwrite, mem_rd);

    // Operand forwarding muxes, resolved before the immediate select
    always_comb begin
        fwd_rs1 = rf_rs1;
        fwd_rs2 = rf_rs2;
        case (sel1)
            FWD_EX:  fwd_rs1 = ex_result;
            FWD_MEM: fwd_rs1 = mem_result;
            default: fwd_rs1 = rf_rs1;
        endcase
        case (sel2)
            FWD_EX:  fwd_rs2 = ex_result;
            FWD_MEM: fwd_rs2 = mem_result;
            default: fwd_rs2 = rf_rs2;
        endcase
    end

    // Immediate extraction and B-operand select
    always_comb begin
        imm = '0;
        case (src)
            SRC_IMM9:  imm = {{(DATA_W-9){bus.instr_in[IMM9_LSB+8]}},  bus.instr_in[IMM9_LSB +: 9]};
            SRC_IMM12: imm = {{(DATA_W-12){1'b0}},                     bus.instr_in[IMM12_LSB +: 12]};
            SRC_IMM19: imm = {{(DATA_W-19){bus.instr_in[IMM19_LSB+18]}}, bus.instr_in[IMM19_LSB +: 19]};
            default:   imm = '0;
        endcase
        op_b = (src == SRC_REG) ? fwd_rs2 : imm;
    end

    // Load in EX feeding this instruction: one bubble is enough because the load moves to MEM
    assign bus.stall = bus.valid_in & ex_valid & ex_memread & (ex_rd != ZR) &
                       ((ex_rd == rs1) | (bus.uses_rs2 & (ex_rd == rs2))) & ~bus.flush;
    assign bus.zero  = (fwd_rs2 == '0);

    // Next ID/EX contents: bubble on flush or stall, otherwise capture
    always_comb begin
        idex_d = '0;
        if (!(bus.flush || bus.stall)) begin
            idex_d.alu_a      = fwd_rs1;
            idex_d.alu_b      = op_b;
            idex_d.store_data = fwd_rs2;
            idex_d.instr      = bus.instr_in;
            idex_d.ctrl       = bus.valid_in ? bus.ctrl_in : '0;
            idex_d.valid      = bus.valid_in;
        end
    end

    // ID/EX boundary register
    always_ff @(posedge clk) begin
        if (reset) idex_q <= '0;
        else       idex_q <= idex_d;
    end

    assign bus.alu_a      = idex_q.alu_a;
    assign bus.alu_b      = idex_q.alu_b;
    assign bus.store_data = idex_q.store_data;
    assign bus.instr_out  = idex_q.instr;
    assign bus.ctrl_out   = idex_q.ctrl;
    assign bus.valid_out  = idex_q.valid;
endmodule

// File: tb/tb_regdec_stage.sv
// Directed vector bench for regdec_stage.
// Latency: checks combinational outputs before the edge, registered outputs after it.
// Backpressure: stall and flush bubbles are covered by vectors and hand sequences.
module tb_regdec_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        ex_valid, ex_regwrite, ex_memread;
    logic [4:0]  ex_rd;
    logic [63:0] ex_result;
    logic        mem_valid, mem_regwrite;
    logic [4:0]  mem_rd;
    logic [63:0] mem_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regdec_if #(.DATA_W(64), .CTRL_W(15)) bus ();

    regdec_stage #(.DATA_W(64), .CTRL_W(15), .ZERO_REG(31)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .ex_valid     (ex_valid),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .ex_rd        (ex_rd),
        .ex_result    (ex_result),
        .mem_valid    (mem_valid),
        .mem_regwrite (mem_regwrite),
        .mem_rd       (mem_rd),
        .mem_result   (mem_result)
    );

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic [14:0] ctrl;
        logic [1:0]  alu_src;
        logic        reg2loc, uses_rs2, flush;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [63:0] wb_data;
        logic        ex_valid, ex_regwrite, ex_memread;
        logic [4:0]  ex_rd;
        logic [63:0] ex_result;
        logic        mem_valid, mem_regwrite;
        logic [4:0]  mem_rd;
        logic [63:0] mem_result;
        logic        e_stall, e_zero;
        logic [63:0] e_a, e_b, e_sd;
        logic        e_vout;
        logic [14:0] e_ctrl;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] r_instr(input logic [4:0] rm, input logic [4:0] rn, input logic [4:0] rd);
        return {11'b10101011000, rm, 6'd0, rn, rd};
    endfunction

    function automatic vec_t base();
        vec_t v;
        v.instr = r_instr(5'd31, 5'd31, 5'd31);
        v.valid = 1'b0;  v.ctrl = 15'h1234; v.alu_src = 2'b00;
        v.reg2loc = 1'b1; v.uses_rs2 = 1'b1; v.flush = 1'b0;
        v.wb_en = 1'b0;  v.wb_addr = 5'd0;  v.wb_data = 64'd0;
        v.ex_valid = 1'b0; v.ex_regwrite = 1'b0; v.ex_memread = 1'b0;
        v.ex_rd = 5'd0;  v.ex_result = 64'd0;
        v.mem_valid = 1'b0; v.mem_regwrite = 1'b0; v.mem_rd = 5'd0; v.mem_result = 64'd0;
        v.e_stall = 1'b0; v.e_zero = 1'b1;
        v.e_a = 64'd0; v.e_b = 64'd0; v.e_sd = 64'd0;
        v.e_vout = 1'b0; v.e_ctrl = 15'd0;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        bus.instr_in = v.instr;   bus.valid_in = v.valid;  bus.ctrl_in = v.ctrl;
        bus.alu_src  = v.alu_src; bus.reg2loc  = v.reg2loc; bus.uses_rs2 = v.uses_rs2;
        bus.flush    = v.flush;
        wb_en = v.wb_en; wb_addr = v.wb_addr; wb_data = v.wb_data;
        ex_valid = v.ex_valid; ex_regwrite = v.ex_regwrite; ex_memread = v.ex_memread;
        ex_rd = v.ex_rd; ex_result = v.ex_result;
        mem_valid = v.mem_valid; mem_regwrite = v.mem_regwrite;
        mem_rd = v.mem_rd; mem_result = v.mem_result;
    endtask

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d got=%h exp=%h", nm, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        logic [31:0] exp_instr;

        // Stimulus table
        v = base(); v.wb_en = 1; v.wb_addr = 0; v.wb_data = 64'd15; tbl.push_back(v);           // 0 X0=15
        v = base(); v.wb_en = 1; v.wb_addr = 1; v.wb_data = 64'd23; tbl.push_back(v);           // 1 X1=23
        v = base(); v.instr = r_instr(1, 0, 2); v.valid = 1; v.ctrl = 15'h0A5;                  // 2 ADDS X2,X0,X1
        v.e_zero = 0; v.e_a = 15; v.e_b = 23; v.e_sd = 23; v.e_vout = 1; v.e_ctrl = 15'h0A5; tbl.push_back(v);
        v = base(); v.instr = r_instr(31, 3, 4); v.valid = 1; v.ctrl = 15'h0A5;                 // 3 bypass X3
        v.wb_en = 1; v.wb_addr = 3; v.wb_data = 64'd77;
        v.e_a = 77; v.e_vout = 1; v.e_ctrl = 15'h0A5; tbl.push_back(v);
        v = base(); v.instr = r_instr(31, 31, 6); v.valid = 1; v.ctrl = 15'h0A5;                // 4 write X31 same cycle
        v.wb_en = 1; v.wb_addr = 31; v.wb_data = 64'd5;
        v.e_vout = 1; v.e_ctrl = 15'h0A5; tbl.push_back(v);
        v = base(); v.instr = r_instr(3, 31, 5); v.valid = 1; v.ctrl = 15'h0A5;                 // 5 X31 still 0
        v.e_zero = 0; v.e_b = 77; v.e_sd = 77; v.e_vout = 1; v.e_ctrl = 15'h0A5; tbl.push_back(v);
        v = base(); v.instr = r_instr(0, 0, 7); v.valid = 1; v.ctrl = 15'h0A5;                  // 6 EX beats MEM
        v.ex_valid = 1; v.ex_regwrite = 1; v.ex_rd = 0; v.ex_result = 64'd165;
        v.mem_valid = 1; v.mem_regwrite = 1; v.mem_rd = 0; v.mem_result = 64'd2341;
        v.e_zero = 0; v.e_a = 165; v.e_b = 165; v.e_sd = 165; v.e_vout = 1; v.e_ctrl = 15'h0A5; tbl.push_back(v);
        v.ex_valid = 0; v.e_a = 2341; v.e_b = 2341; v.e_sd = 2341; tbl.push_back(v);            // 7 MEM only
        v = base(); v.instr = r_instr(1, 0, 8); v.valid = 1; v.ctrl = 15'h0A5;                  // 8 EX beats wb
        v.ex_valid = 1; v.ex_regwrite = 1; v.ex_rd = 0; v.ex_result = 64'd165;
        v.wb_en = 1; v.wb_addr = 0; v.wb_data = 64'd999;
        v.e_zero = 0; v.e_a = 165; v.e_b = 23; v.e_sd = 23; v.e_vout = 1; v.e_ctrl = 15'h0A5; tbl.push_back(v);
        v = base(); v.instr = 32'h001FF000 | (32'd1 << 5) | 32'd3; v.valid = 1; v.ctrl = 15'h0A5; // 9 imm9 = -1
        v.alu_src = 2'b01; v.reg2loc = 0;
        v.mem_valid = 1; v.mem_regwrite = 1; v.mem_rd = 3; v.mem_result = 64'd500;
        v.e_zero = 0; v.e_a = 23; v.e_b = 64'hFFFF_FFFF_FFFF_FFFF; v.e_sd = 500; v.e_vout = 1; v.e_ctrl = 15'h0A5; tbl.push_back(v);
        v = base(); v.instr = 32'h003FFC00 | (32'd1 << 5) | 32'd3; v.valid = 1; v.ctrl = 15'h0A5; // 10 imm12 = 4095
        v.alu_src = 2'b10; v.reg2loc = 0;
        v.e_zero = 0; v.e_a = 23; v.e_b = 64'd4095; v.e_sd = 77; v.e_vout = 1; v.e_ctrl = 15'h0A5; tbl.push_back(v);
        v = base(); v.instr = 32'h00800000 | 32'd3; v.valid = 1; v.ctrl = 15'h0A5;              // 11 imm19 negative
        v.alu_src = 2'b11; v.reg2loc = 0;
        v.e_zero = 0; v.e_a = 999; v.e_b = 64'hFFFF_FFFF_FFFC_0000; v.e_sd = 77; v.e_vout = 1; v.e_ctrl = 15'h0A5; tbl.push_back(v);
        v = base(); v.instr = r_instr(1, 4, 9); v.valid = 1; v.ctrl = 15'h0A5;                  // 12 load-use on rs1
        v.ex_valid = 1; v.ex_regwrite = 1; v.ex_memread = 1; v.ex_rd = 4; v.ex_result = 64'hDEAD;
        v.e_stall = 1; v.e_zero = 0; tbl.push_back(v);
        v.ex_valid = 0; v.ex_memread = 0; v.ex_regwrite = 0;                                     // 13 load now in MEM
        v.mem_valid = 1; v.mem_regwrite = 1; v.mem_rd = 4; v.mem_result = 64'd4444;
        v.e_stall = 0; v.e_a = 4444; v.e_b = 23; v.e_sd = 23; v.e_vout = 1; v.e_ctrl = 15'h0A5; tbl.push_back(v);
        v = base(); v.instr = r_instr(1, 31, 10); v.valid = 1; v.ctrl = 15'h0A5; v.uses_rs2 = 0; // 14 rs2 match ignored
        v.ex_valid = 1; v.ex_regwrite = 1; v.ex_memread = 1; v.ex_rd = 1; v.ex_result = 64'h55;
        v.e_zero = 0; v.e_b = 64'h55; v.e_sd = 64'h55; v.e_vout = 1; v.e_ctrl = 15'h0A5; tbl.push_back(v);
        v.uses_rs2 = 1; v.e_stall = 1; v.e_b = 0; v.e_sd = 0; v.e_vout = 0; v.e_ctrl = 0;       // 15 rs2 load-use
        tbl.push_back(v);
        v = base(); v.instr = r_instr(31, 31, 11); v.valid = 1; v.ctrl = 15'h0A5;               // 16 load to X31
        v.ex_valid = 1; v.ex_regwrite = 1; v.ex_memread = 1; v.ex_rd = 31; v.ex_result = 64'h77;
        v.e_vout = 1; v.e_ctrl = 15'h0A5; tbl.push_back(v);
        v = base(); v.instr = r_instr(1, 4, 9); v.valid = 1; v.ctrl = 15'h0A5; v.flush = 1;     // 17 flush beats stall
        v.ex_valid = 1; v.ex_regwrite = 1; v.ex_memread = 1; v.ex_rd = 4; v.ex_result = 64'hDEAD;
        v.e_zero = 0; tbl.push_back(v);

        // Reset state
        reset = 1'b1;
        apply(base());
        step();
        step();
        chk("rst_alu_a", -1, bus.alu_a, 64'd0);
        chk("rst_alu_b", -1, bus.alu_b, 64'd0);
        chk("rst_store", -1, bus.store_data, 64'd0);
        chk("rst_instr", -1, 64'(bus.instr_out), 64'd0);
        chk("rst_ctrl",  -1, 64'(bus.ctrl_out), 64'd0);
        chk("rst_valid", -1, 64'(bus.valid_out), 64'd0);
        chk("rst_stall", -1, 64'(bus.stall), 64'd0);
        reset = 1'b0;

        // Table loop
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            #1;
            chk("stall", i, 64'(bus.stall), 64'(tbl[i].e_stall));
            chk("zero",  i, 64'(bus.zero),  64'(tbl[i].e_zero));
            step();
            exp_instr = (tbl[i].e_stall || tbl[i].flush) ? 32'd0 : tbl[i].instr;
            chk("alu_a",      i, bus.alu_a,      tbl[i].e_a);
            chk("alu_b",      i, bus.alu_b,      tbl[i].e_b);
            chk("store_data", i, bus.store_data, tbl[i].e_sd);
            chk("valid_out",  i, 64'(bus.valid_out), 64'(tbl[i].e_vout));
            chk("ctrl_out",   i, 64'(bus.ctrl_out),  64'(tbl[i].e_ctrl));
            chk("instr_out",  i, 64'(bus.instr_out), 64'(exp_instr));
        end

        // Reset asserted mid-stream while a stall condition is present
        v = base(); v.instr = r_instr(1, 0, 2); v.valid = 1; v.ctrl = 15'h0A5;
        apply(v);
        step();
        chk("pre_rst_a",     100, bus.alu_a, 64'd999);
        chk("pre_rst_b",     100, bus.alu_b, 64'd23);
        chk("pre_rst_valid", 100, 64'(bus.valid_out), 64'd1);
        v.ex_valid = 1; v.ex_regwrite = 1; v.ex_memread = 1; v.ex_rd = 0;
        apply(v);
        reset = 1'b1;
        #1;
        chk("mid_rst_stall", 101, 64'(bus.stall), 64'd1);
        step();
        chk("mid_rst_a",     101, bus.alu_a, 64'd0);
        chk("mid_rst_b",     101, bus.alu_b, 64'd0);
        chk("mid_rst_valid", 101, 64'(bus.valid_out), 64'd0);
        chk("mid_rst_ctrl",  101, 64'(bus.ctrl_out), 64'd0);
        chk("mid_rst_instr", 101, 64'(bus.instr_out), 64'd0);
        reset = 1'b0;
        v.ex_valid = 0; v.ex_regwrite = 0; v.ex_memread = 0;
        apply(v);
        step();
        chk("post_rst_a",     102, bus.alu_a, 64'd0);
        chk("post_rst_b",     102, bus.alu_b, 64'd0);
        chk("post_rst_valid", 102, 64'(bus.valid_out), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regdec_stage.md
# regdec_stage

Parametrised register-read/decode pipeline stage for the pipelined ARM-subset CPU, sitting between the IF/ID register and the EX stage. It contains its own register file with same-cycle write-back bypass, full EX/MEM forwarding on both operands and the store-data path, load-use hazard detection with bubble insertion, and a flush input for taken branches. It registers operands, instruction and control word into the ID/EX boundary with a valid bit.

## Interface
Parameters:
- DATA_W, 64, datapath and register width
- CTRL_W, 15, width of the opaque control word passed to EX
- ZERO_REG, 31, register index that reads 0 and ignores writes

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  stage clock, all state on posedge
- reset  in  1  synchronous active-high reset
- instr_in  in  32  instruction from IF/ID
- valid_in  in  1  instr_in is a real instruction
- ctrl_in  in  CTRL_W  control word from main decoder
- alu_src  in  2  B-operand source: 00 reg, 01 sext imm9 [20:12], 10 zext imm12 [21:10], 11 sext imm19 [23:5]
- reg2loc  in  1  1: rs2 = instr[20:16]; 0: rs2 = instr[4:0]
- uses_rs2  in  1  instruction reads rs2 (hazard qualification)
- flush  in  1  squash the instruction currently in this stage
- wb_en, wb_addr, wb_data  in  1/5/DATA_W  write-back port
- ex_valid, ex_regwrite, ex_memread  in  1 each  EX-stage status
- ex_rd, ex_result  in  5/DATA_W  EX destination and ALU result
- mem_valid, mem_regwrite, mem_rd, mem_result  in  1/1/5/DATA_W  MEM-stage status and result
- stall  out  1  combinational; hold PC and IF/ID
- zero  out  1  combinational; forwarded rs2 value == 0 (CBZ)
- alu_a, alu_b, store_data  out  DATA_W  registered operands
- instr_out  out  32  registered instruction
- ctrl_out  out  CTRL_W  registered control word
- valid_out  out  1  registered valid

## Operation
- rs1 = instr_in[9:5]; rs2 per reg2loc.
- Register read: ZERO_REG reads 0. Else if wb_en and wb_addr == rsN and wb_addr != ZERO_REG, value = wb_data (bypass); else array value.
- Forwarding per operand (priority high to low): EX match (ex_valid & ex_regwrite & ex_rd == rsN & rsN != ZERO_REG) -> ex_result; MEM match (same form) -> mem_result; else register read.
- Forwarding is applied before the alu_src mux: alu_b = alu_src==00 ? fwd_rs2 : immediate. store_data = fwd_rs2 always. alu_a = fwd_rs1.
- zero = (fwd_rs2 == 0), independent of alu_src.
- Load-use hazard: stall = valid_in & ex_valid & ex_memread & ex_rd != ZERO_REG & (ex_rd == rs1 | (uses_rs2 & ex_rd == rs2)) & ~flush.
- Next-state: reset -> all zero. Else if flush or stall -> bubble: valid_out=0, ctrl_out=0, operands/instr_out=0. Else capture valid_in, ctrl_in (zeroed if ~valid_in), operands, instr_in.
- Register array write: wb_en & wb_addr != ZERO_REG writes wb_data on posedge; independent of stall/flush.

## Timing
- Latency 1 cycle, instr_in to ID/EX outputs.
- Reset: alu_a, alu_b, store_data, instr_out, ctrl_out = 0, valid_out = 0, all registers = 0.
- stall lasts exactly one cycle per load-use pair (bubble enters EX, so the next cycle EX no longer holds the load).
- flush and stall in the same cycle: flush wins, stall = 0.
- EX and MEM both match: EX value used. wb_addr == ex_rd == rs1: EX value used.
- Reset asserted mid-stall: outputs zero next cycle, stall follows its combinational equation.

## Structure
- regdec_pkg: alu_src_e enum (SRC_REG, SRC_IMM9, SRC_IMM12, SRC_IMM19), fwd_sel_e (FWD_REG, FWD_EX, FWD_MEM), instruction field bit-position constants.
- One sub-module: regfile_bypass (32 x DATA_W, synchronous reset, ZERO_REG hardwired, two read ports with write bypass).

## Test plan
- Write X0=15, X1=23 via wb; ADDS X2,X0,X1 (reg2loc=1, alu_src=00) -> next cycle alu_a=15, alu_b=23, valid_out=1.
- wb_en writes X3=77 in the same cycle an instruction reads X3 -> alu_a=77 (bypass); write to X31=5 -> reads of X31 return 0.
- ex_result=165 (rd=X0), mem_result=2341 (rd=X0), read X0 on both operands -> alu_a=alu_b=store_data=165; EX invalid -> 2341.
- alu_src=01 with instr[20:12]=9'h1FF -> alu_b=-1 sign-extended; alu_src=10 with imm12=12'hFFF -> alu_b=4095; store_data still forwarded rs2.
- LDUR X4 in EX (ex_memread=1), ADD reads X4 -> stall=1 for one cycle, valid_out=0, ctrl_out=0; next cycle stall=0, instruction issues with MEM-forwarded load data.
- flush with stall condition present -> stall=0, valid_out=0 next cycle; reset mid-stream -> all outputs 0 next cycle.
